// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac
// Fractional-divider UART baud generator with oversampling ticks.
// A phase accumulator stretches some periods by one cycle, so that the
// average period is div_int + div_frac/2^DIV_FRAC_W clk cycles.
//
// Ports:
//   clk       - clock
//   rst       - asynchronous, active-high reset
//   en        - enable; when low, counters and accumulator are held at 0
//   div_int   - requested integer divisor (must be >= 2)
//   div_frac  - requested fractional divisor
//   div_load  - strobe capturing div_int/div_frac into the pending register
//   resync    - strobe restarting the tick phase (RX start-edge alignment)
//   os_tick   - one-cycle oversample tick
//   baud_tick - one-cycle tick on the os_tick that wraps the oversample count
//   mid_tick  - one-cycle tick on the os_tick at bit centre (index OVS/2-1)
//   div_err   - one-cycle pulse when a div_load is rejected
module uart_baud_gen_frac #(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4,
  parameter int OVS        = 16,
  parameter int DEF_INT    = 27,
  parameter int DEF_FRAC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  div_load,
  input  logic                  resync,
  output logic                  os_tick,
  output logic                  baud_tick,
  output logic                  mid_tick,
  output logic                  div_err
);

  localparam int OS_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0]      OS_MID  = OS_W'(OVS / 2 - 1);
  localparam logic [DIV_INT_W-1:0] INT_MIN = DIV_INT_W'(2);

  // One extra bit so that the longest period (max divisor + carry) fits.
  logic [DIV_INT_W:0]    cnt_reg;
  logic [DIV_FRAC_W-1:0] acc_reg;
  logic                  long_reg;   // current period is stretched by one cycle
  logic [OS_W-1:0]       os_cnt_reg;

  logic [DIV_INT_W-1:0]  int_act_reg;
  logic [DIV_FRAC_W-1:0] frac_act_reg;
  logic [DIV_INT_W-1:0]  int_pend_reg;
  logic [DIV_FRAC_W-1:0] frac_pend_reg;
  logic                  pend_valid_reg;

  logic [DIV_FRAC_W:0]   sum;
  logic [DIV_INT_W:0]    cnt_last;
  logic                  period_end;
  logic                  load_ok;
  logic                  apply_pend;

  always_comb begin
    sum        = {1'b0, acc_reg} + {1'b0, frac_act_reg};
    cnt_last   = {1'b0, int_act_reg} + (DIV_INT_W+1)'(long_reg) - (DIV_INT_W+1)'(1);
    // cnt_reg == 0 is always the period-start cycle; len >= 2 keeps it apart
    // from the terminal count.
    period_end = (cnt_reg != '0) && (cnt_reg == cnt_last);
    load_ok    = div_load && (div_int >= INT_MIN);
    apply_pend = !en || resync || period_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      acc_reg        <= '0;
      long_reg       <= 1'b0;
      os_cnt_reg     <= '0;
      int_act_reg    <= DIV_INT_W'(DEF_INT);
      frac_act_reg   <= DIV_FRAC_W'(DEF_FRAC);
      int_pend_reg   <= '0;
      frac_pend_reg  <= '0;
      pend_valid_reg <= 1'b0;
      os_tick        <= 1'b0;
      baud_tick      <= 1'b0;
      mid_tick       <= 1'b0;
      div_err        <= 1'b0;
    end else begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      mid_tick  <= 1'b0;
      div_err   <= div_load && (div_int < INT_MIN);

      // The pending divisor is consumed before a same-cycle load is captured,
      // so a simultaneous load always lands in the pending register.
      if (apply_pend && pend_valid_reg) begin
        int_act_reg    <= int_pend_reg;
        frac_act_reg   <= frac_pend_reg;
        pend_valid_reg <= 1'b0;
      end
      if (load_ok) begin
        int_pend_reg   <= div_int;
        frac_pend_reg  <= div_frac;
        pend_valid_reg <= 1'b1;
      end

      if (!en || resync) begin
        cnt_reg    <= '0;
        acc_reg    <= '0;
        long_reg   <= 1'b0;
        os_cnt_reg <= '0;
      end else if (cnt_reg == '0) begin
        // Period start: advance the phase accumulator; its carry lengthens
        // this period by one cycle.
        acc_reg  <= sum[DIV_FRAC_W-1:0];
        long_reg <= sum[DIV_FRAC_W];
        cnt_reg  <= (DIV_INT_W+1)'(1);
      end else if (period_end) begin
        cnt_reg  <= '0;
        os_tick  <= 1'b1;
        mid_tick <= (os_cnt_reg == OS_MID);
        if (os_cnt_reg == OS_LAST) begin
          baud_tick  <= 1'b1;
          os_cnt_reg <= '0;
        end else begin
          os_cnt_reg <= os_cnt_reg + OS_W'(1);
        end
      end else begin
        cnt_reg <= cnt_reg + (DIV_INT_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
module tb_uart_baud_gen_frac;

  localparam int OVS = 16;
  localparam int FR  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        os_tick, baud_tick, mid_tick, div_err;

  uart_baud_gen_frac #(
    .DIV_INT_W(16), .DIV_FRAC_W(4), .OVS(OVS), .DEF_INT(27), .DEF_FRAC(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .resync(resync), .os_tick(os_tick),
    .baud_tick(baud_tick), .mid_tick(mid_tick), .div_err(div_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string nm, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the absolute cycle at which the next os_tick is due.
  int m_cyc = 0;
  bit m_start;
  int m_tick_at;
  int m_acc, m_os, m_int, m_frac, m_pint, m_pfrac, m_sum;
  bit m_pv, m_apply;
  bit e_os, e_baud, e_mid, e_err;

  task automatic model_reset();
    m_start = 1; m_tick_at = -1; m_acc = 0; m_os = 0;
    m_int = 27; m_frac = 2; m_pv = 0; m_pint = 0; m_pfrac = 0;
    e_os = 0; e_baud = 0; e_mid = 0; e_err = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      e_os = 0; e_baud = 0; e_mid = 0;
      e_err = div_load && (int'(div_int) < 2);
      m_apply = 0;
      if (!en || resync) begin
        m_start = 1; m_acc = 0; m_os = 0; m_tick_at = -1; m_apply = 1;
      end else begin
        if (m_start) begin
          m_sum = m_acc + m_frac;
          m_acc = m_sum % FR;
          m_tick_at = m_cyc + m_int + m_sum / FR;
          m_start = 0;
        end
        if (m_cyc + 1 == m_tick_at) begin
          e_os = 1;
          e_mid = (m_os == OVS / 2 - 1);
          if (m_os == OVS - 1) begin e_baud = 1; m_os = 0; end
          else m_os = m_os + 1;
          m_start = 1;
          m_apply = 1;
        end
      end
      if (m_apply && m_pv) begin m_int = m_pint; m_frac = m_pfrac; m_pv = 0; end
      if (div_load && int'(div_int) >= 2) begin
        m_pint = int'(div_int); m_pfrac = int'(div_frac); m_pv = 1;
      end
    end
    m_cyc++;
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] act, exp;
    act = {os_tick, baud_tick, mid_tick, div_err};
    exp = rst ? 4'b0000 : {e_os, e_baud, e_mid, e_err};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cycle: os/baud/mid/err got %b expected %b (t=%0t)", act, exp, $time);
    end
  end

  // Counts from the current (period-start) cycle: k=0 now. Checks first tick
  // latency, cycles until the 16th os_tick, and one baud/mid tick per 16.
  task automatic measure(input int exp_first, input int exp_total, input string nm);
    int k = 0, n = 0, first = -1, bauds = 0, mids = 0;
    while (n < OVS && k < 3000) begin
      if (os_tick) begin
        n++;
        if (n == 1) first = k;
      end
      bauds += int'(baud_tick);
      mids  += int'(mid_tick);
      if (n < OVS) begin
        @(negedge clk);
        k++;
      end
    end
    check(first == exp_first, {nm, "_first_tick"}, first, exp_first);
    check(n == OVS && k == exp_total, {nm, "_16_periods"}, k, exp_total);
    check(bauds == 1, {nm, "_baud_count"}, bauds, 1);
    check(mids == 1, {nm, "_mid_count"}, mids, 1);
  endtask

  task automatic do_resync();
    @(negedge clk); resync = 1'b1;
    @(negedge clk); resync = 1'b0;
  endtask

  typedef struct {
    int di;
    int df;
    int exp_first;
    int exp_total;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cnt;
    tbl[0] = '{4, 0, 4, 64};
    tbl[1] = '{27, 2, 27, 434};
    tbl[2] = '{5, 3, 5, 83};
    tbl[3] = '{2, 15, 2, 47};
    tbl[4] = '{7, 8, 7, 120};
    tbl[5] = '{3, 1, 3, 49};

    // Reset defaults.
    repeat (3) @(negedge clk);
    #1;
    check({os_tick, baud_tick, mid_tick, div_err} == 4'b0, "reset_outputs",
          int'({os_tick, baud_tick, mid_tick, div_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    measure(27, 434, "defaults");

    // Enable dropped for 100 cycles, then restored.
    @(negedge clk); en = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      cnt += int'(os_tick) + int'(baud_tick) + int'(mid_tick);
    end
    check(cnt == 0, "en_low_no_ticks", cnt, 0);
    en = 1'b1;
    measure(27, 434, "en_restore");

    // Rejected load.
    @(negedge clk); div_load = 1'b1; div_int = 16'd1; div_frac = 4'd5;
    @(negedge clk); div_load = 1'b0;
    check(div_err == 1'b1, "div_err_pulse", int'(div_err), 1);
    @(negedge clk);
    check(div_err == 1'b0, "div_err_one_cycle", int'(div_err), 0);
    do_resync();
    measure(27, 434, "after_reject");

    // Table: load then resync, check period pattern from acc = 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      div_load = 1'b1; div_int = 16'(tbl[i].di); div_frac = 4'(tbl[i].df);
      @(negedge clk);
      div_load = 1'b0;
      resync = 1'b1;
      @(negedge clk);
      resync = 1'b0;
      measure(tbl[i].exp_first, tbl[i].exp_total, $sformatf("vec%0d", i));
    end

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) en = ~en;
      div_load = ($urandom_range(0, 59) == 0);
      div_int  = 16'($urandom_range(0, 7));
      div_frac = 4'($urandom_range(0, 15));
      resync   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    en = 1'b1; div_load = 1'b0; resync = 1'b0;

    // Asynchronous reset while os_tick is high.
    cnt = 0;
    while (!os_tick && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check(os_tick == 1'b1, "wait_tick_before_reset", int'(os_tick), 1);
    #2 rst = 1'b1;
    #1;
    check({os_tick, baud_tick, mid_tick, div_err} == 4'b0, "async_reset_clears",
          int'({os_tick, baud_tick, mid_tick, div_err}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    measure(27, 434, "post_reset");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
